// File: rtl/sram_responder.sv
// sram_responder
// Data-memory responder behind the MEM stage. Accepts one word request at a
// time, performs a byte-strobed write or a word read on an internal array
// mapped at BASE_ADDR, and presents the response LATENCY cycles after accept.
//
// Ports:
//   clock       sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept (high only in IDLE)
//   req_we      1 = write, 0 = read
//   req_addr    byte address (bits [1:0] ignored)
//   req_wdata   write data
//   req_wstrb   byte enables, bit i selects lane [8i+7:8i]
//   resp_valid  response present (RESP state)
//   resp_ready  initiator accepts the response
//   resp_rdata  read data, 0 for writes and misses
//   resp_err    address fell outside the mapped window
module sram_responder #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h1c000000,
  parameter int unsigned            LATENCY     = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned           STRB_W = DATA_WIDTH / 8;
  localparam int unsigned           IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
  // WAIT runs LATENCY-2 extra cycles; unused when LATENCY = 1.
  localparam logic [2:0]            CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   word_off;
  logic [IDX_W-1:0]        idx;
  logic                    in_win;
  logic                    accept;

  // The subtraction is only trusted when req_addr >= BASE_ADDR, so the
  // window test never sees a wrapped offset. The index compare uses the full
  // shifted offset so high address bits cannot alias into the array.
  assign offset   = req_addr - BASE_ADDR;
  assign word_off = offset >> 2;
  assign in_win   = (req_addr >= BASE_ADDR) && (word_off < DEPTH_A);
  assign idx      = word_off[IDX_W-1:0];

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = (in_win && !req_we) ? mem_q[idx] : '0;
          err_d   = !in_win;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array keeps its contents through reset; the reset branch only stops
  // a request presented while reset is asserted from writing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
    end else if (accept && req_we && in_win) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (req_wstrb[i]) begin
          mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: two instances (LATENCY 3 and LATENCY 1),
// a word-array reference model, and a scoreboard monitor per instance.
module tb_sram_responder;

  localparam logic [31:0] BASE  = 32'h1c000000;
  localparam int          DEPTH = 1024;
  localparam int          LAT_A = 3;
  localparam int          LAT_B = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        a_reset_n, a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_wstrb;
  logic        b_reset_n, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wstrb;

  sram_responder #(.LATENCY(LAT_A)) u_a (
    .clock(clock), .reset_n(a_reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  sram_responder #(.LATENCY(LAT_B)) u_b (
    .clock(clock), .reset_n(b_reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] known;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  bit          busy [2];
  logic [31:0] cur_d [2];
  logic        cur_e [2];
  logic [31:0] mdata [2][DEPTH];
  logic [3:0]  mknown [2][DEPTH];
  bit          hold0 = 1'b0;
  bit          force0 = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Response backpressure: random, except when the directed test pins it.
  initial begin
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      a_resp_ready = hold0 ? 1'b0 : (force0 ? 1'b1 : ($urandom_range(0, 2) != 0));
      b_resp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic mon(input int inst, input logic v, input logic r, input logic [31:0] d, input logic e);
    exp_t x;
    bit   got;
    int   lat;
    lat = (inst == 0) ? LAT_A : LAT_B;
    if (v) begin
      if (!busy[inst]) begin
        got = 1'b0;
        if (inst == 0 && q0.size() > 0) begin x = q0.pop_front(); got = 1'b1; end
        else if (inst == 1 && q1.size() > 0) begin x = q1.pop_front(); got = 1'b1; end
        if (!got) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp inst=%0d: got rdata=%h err=%b want no response", inst, d, e);
        end else begin
          chk($sformatf("latency%0d", inst), 32'(cyc), 32'(x.acc + lat - 1));
          chk($sformatf("rdata%0d", inst), d & x.known, x.data & x.known);
          chk1($sformatf("err%0d", inst), e, x.err);
        end
        busy[inst]  = 1'b1;
        cur_d[inst] = d;
        cur_e[inst] = e;
      end else begin
        chk($sformatf("hold_rdata%0d", inst), d, cur_d[inst]);
        chk1($sformatf("hold_err%0d", inst), e, cur_e[inst]);
      end
      if (r) busy[inst] = 1'b0;
    end else if (busy[inst]) begin
      total++;
      bad++;
      $display("FAIL dropped_resp inst=%0d: got resp_valid=0 want 1 until consumed", inst);
      busy[inst] = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    mon(0, a_resp_valid, a_resp_ready, a_resp_rdata, a_resp_err);
    mon(1, b_resp_valid, b_resp_ready, b_resp_rdata, b_resp_err);
  end

  function automatic logic rdy(input int inst);
    return (inst == 0) ? a_req_ready : b_req_ready;
  endfunction

  // Drives one request, waits for accept, then records the expected response
  // and applies the write to the reference array.
  task automatic issue(input int inst, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    exp_t   x;
    int     n;
    longint off;
    int     idx;
    bit     hit;
    if (inst == 0) begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_wstrb = st;
    end else begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_wstrb = st;
    end
    n = 0;
    while (rdy(inst) !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL accept_timeout inst=%0d: got req_ready=0 want 1 within 100 cycles", inst);
    end else begin
      @(posedge clock);
      #1;
      off    = longint'(addr) - longint'(BASE);
      hit    = (off >= 0) && (off < longint'(4 * DEPTH));
      x.acc  = cyc;
      x.err  = !hit;
      x.data = 32'h0;
      x.known = 32'hffffffff;
      if (hit) begin
        idx = int'(off / 4);
        if (we) begin
          for (int l = 0; l < 4; l++) begin
            if (st[l]) begin
              mdata[inst][idx][8*l +: 8] = wd[8*l +: 8];
              mknown[inst][idx][l] = 1'b1;
            end
          end
        end else begin
          x.data = mdata[inst][idx];
          for (int l = 0; l < 4; l++) x.known[8*l +: 8] = {8{mknown[inst][idx][l]}};
        end
      end
      if (inst == 0) q0.push_back(x);
      else q1.push_back(x);
    end
    if (inst == 0) a_req_valid = 1'b0;
    else b_req_valid = 1'b0;
  endtask

  task automatic drain(input int inst);
    int n;
    n = 0;
    while (n < 200 && !(((inst == 0) ? q0.size() : q1.size()) == 0 && !busy[inst] && rdy(inst) === 1'b1)) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout inst=%0d: got responses outstanding want none within 200 cycles", inst);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6) return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
    else if (s < 8) return BASE + 32'(4 * DEPTH - 64) + 32'($urandom_range(0, 127));
    else if (s == 8) return BASE - 32'($urandom_range(1, 8));
    else return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      mknown[0][i] = 4'h0;
      mknown[1][i] = 4'h0;
    end
    a_reset_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0;
    b_reset_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    repeat (3) @(posedge clock);
    #1;
    chk1("rst_req_ready_a", a_req_ready, 1'b1);
    chk1("rst_resp_valid_a", a_resp_valid, 1'b0);
    chk("rst_rdata_a", a_resp_rdata, 32'h0);
    chk1("rst_err_a", a_resp_err, 1'b0);
    chk1("rst_req_ready_b", b_req_ready, 1'b1);
    chk1("rst_resp_valid_b", b_resp_valid, 1'b0);
    chk("rst_rdata_b", b_resp_rdata, 32'h0);
    chk1("rst_err_b", b_resp_err, 1'b0);
    @(negedge clock);
    a_reset_n = 1'b1;
    b_reset_n = 1'b1;
    @(posedge clock);
    #1;

    // LATENCY = 1: write/read, byte strobes, zero strobe, low address bits
    issue(1, 1'b1, 32'h1c000010, 32'hdec0de11, 4'hf);
    issue(1, 1'b0, 32'h1c000010, 32'h0, 4'h0);
    issue(1, 1'b1, BASE, 32'h11223344, 4'hf);
    issue(1, 1'b1, BASE, 32'haabbccdd, 4'b0101);
    issue(1, 1'b0, BASE, 32'h0, 4'h0);
    issue(1, 1'b1, BASE, 32'hffffffff, 4'h0);
    issue(1, 1'b0, BASE, 32'h0, 4'h0);
    issue(1, 1'b0, 32'h1c000013, 32'h0, 4'h0);
    for (int i = 0; i < 150; i++) issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
    drain(1);

    // LATENCY = 3: address window edges
    issue(0, 1'b1, BASE, 32'h0badf00d, 4'hf);
    issue(0, 1'b1, 32'h1c000ffc, 32'h5eed1234, 4'hf);
    issue(0, 1'b1, 32'h1bfffffc, 32'hdeadbeef, 4'hf);
    issue(0, 1'b1, 32'h1c001000, 32'hfeedface, 4'hf);
    issue(0, 1'b0, 32'h1bfffffc, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h1c001000, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h1bffffff, 32'h0, 4'h0);
    issue(0, 1'b0, BASE, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h1c000ffc, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h1c000fff, 32'h0, 4'h0);
    issue(0, 1'b1, 32'h1c000010, 32'h600dcafe, 4'hf);
    issue(0, 1'b0, 32'h1c000013, 32'h0, 4'h0);
    drain(0);

    // Backpressure: hold resp_ready low for four cycles of valid response
    hold0 = 1'b1;
    @(posedge clock);
    #1;
    issue(0, 1'b0, 32'h1c000010, 32'h0, 4'h0);
    @(negedge clock);
    n = 0;
    while (a_resp_valid !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk1("bp_req_ready_low", a_req_ready, 1'b0);
      chk1("bp_resp_valid_high", a_resp_valid, 1'b1);
      @(negedge clock);
    end
    hold0  = 1'b0;
    force0 = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk1("bp_req_ready_after", a_req_ready, 1'b1);
    chk1("bp_resp_valid_after", a_resp_valid, 1'b0);
    force0 = 1'b0;
    @(posedge clock);
    #1;

    // Reset while a LATENCY = 3 write sits in WAIT
    issue(0, 1'b1, 32'h1c000024, 32'h01234567, 4'hf);
    drain(0);
    issue(0, 1'b1, 32'h1c000020, 32'hcafef00d, 4'hf);
    @(negedge clock);
    a_reset_n = 1'b0;
    #1;
    q0.delete();
    busy[0] = 1'b0;
    chk1("rst_mid_resp_valid", a_resp_valid, 1'b0);
    chk1("rst_mid_req_ready", a_req_ready, 1'b1);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h1c000024; a_req_wdata = 32'hffffffff; a_req_wstrb = 4'hf;
    repeat (2) @(posedge clock);
    @(negedge clock);
    a_reset_n   = 1'b1;
    a_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      #1;
      chk1("no_resp_after_rst", a_resp_valid, 1'b0);
    end
    @(posedge clock);
    #1;
    issue(0, 1'b0, 32'h1c000020, 32'h0, 4'h0);
    issue(0, 1'b0, 32'h1c000024, 32'h0, 4'h0);

    for (int i = 0; i < 150; i++) issue(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
    drain(0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
